song_player: RTL

Playback end of the song path: snapshots the two 32-bit song words produced by the song editor and steps through them one position per beat. It presents the current and upcoming note to the display/LED logic. It also judges player key presses against the current note and keeps hit and miss counts. It sits beside the editor under the game top level and is active only in play mode.

---
 rtl/guitar_pkg.sv | 24 ++
 rtl/beat_timer.sv | 30 +++
 rtl/song_player.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/guitar_pkg.sv
// Shared mode constants, note codes and player state encoding for the guitar game.
package guitar_pkg;

  localparam logic [2:0] MODE_EDIT = 3'd2;
  localparam logic [2:0] MODE_PLAY = 3'd3;

  typedef enum logic [1:0] {
    REST = 2'b00,
    N1   = 2'b01,
    N2   = 2'b10,
    N3   = 2'b11
  } note_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } player_state_t;

  function automatic logic is_playable(input logic [1:0] n);
    return n != REST;
  endfunction

endpackage

// File: rtl/beat_timer.sv
// Beat counter: free-runs 0..BEAT_DIV-1 while run is high; tick is combinational at terminal count.
// clear has priority and parks the counter at zero so the first tick lands BEAT_DIV cycles later.
module beat_timer #(
  parameter int BEAT_DIV = 10_000_000
) (
  input  logic clk,
  input  logic nrst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = $clog2(BEAT_DIV);
  localparam logic [CW-1:0] LAST = CW'(BEAT_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = run && !clear && (r_cnt == LAST);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= tick ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/song_player.sv
// Song playback: snapshots the editor's song words, steps one position per beat,
// and judges key presses against the current note with hit/miss counters.
module song_player
  import guitar_pkg::*;
#(
  parameter int         BEAT_DIV  = 10_000_000,
  parameter int         SONG_LEN  = 32,
  parameter logic [2:0] PLAY_MODE = MODE_PLAY
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [2:0]  mode,
  input  logic        start,
  input  logic [31:0] note1,
  input  logic [31:0] note2,
  input  logic        key_valid,
  input  logic [1:0]  key_note,
  output logic [4:0]  position,
  output logic [1:0]  cur_note,
  output logic [1:0]  next_note,
  output logic        beat,
  output logic        playing,
  output logic        done,
  output logic        hit_pulse,
  output logic        miss_pulse,
  output logic [5:0]  hit_count,
  output logic [5:0]  miss_count
);

  localparam logic [4:0] LAST_POS = 5'(SONG_LEN - 1);

  player_state_t r_state;
  logic [31:0]   r_snap1;
  logic [31:0]   r_snap2;
  logic [4:0]    r_position;
  logic          r_judged;
  logic          r_beat;
  logic          r_playing;
  logic          r_done;
  logic          r_hit_pulse;
  logic          r_miss_pulse;
  logic [5:0]    r_hit_count;
  logic [5:0]    r_miss_count;

  logic       w_tick;
  logic       w_in_play;
  logic       w_mode_ok;
  logic       w_go;
  logic       w_judge;
  logic       w_press_hit;
  logic       w_press_miss;
  logic       w_eob_miss;
  logic [4:0] w_pos_inc;

  beat_timer #(
    .BEAT_DIV (BEAT_DIV)
  ) u_beat_timer (
    .clk   (clk),
    .nrst  (nrst),
    .run   (w_in_play),
    .clear (!w_in_play),
    .tick  (w_tick)
  );

  assign w_pos_inc = r_position + 5'd1;
  assign cur_note  = {r_snap2[r_position], r_snap1[r_position]};
  assign next_note = (r_position == LAST_POS) ? 2'b00
                                              : {r_snap2[w_pos_inc], r_snap1[w_pos_inc]};

  assign w_mode_ok = (mode == PLAY_MODE);
  assign w_in_play = (r_state == ST_PLAY);
  assign w_go      = start && w_mode_ok && !w_in_play;

  // A press in the terminal cycle is judged first, so it suppresses the end-of-beat miss.
  assign w_judge      = w_in_play && w_mode_ok && key_valid && !r_judged;
  assign w_press_hit  = w_judge && is_playable(cur_note) && (key_note == cur_note);
  assign w_press_miss = w_judge && !w_press_hit;
  assign w_eob_miss   = w_in_play && w_mode_ok && w_tick && !r_judged && !key_valid &&
                        is_playable(cur_note);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= ST_IDLE;
      r_snap1      <= '0;
      r_snap2      <= '0;
      r_position   <= '0;
      r_judged     <= 1'b0;
      r_beat       <= 1'b0;
      r_playing    <= 1'b0;
      r_done       <= 1'b0;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_beat       <= 1'b0;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_go) begin
            r_state      <= ST_PLAY;
            r_snap1      <= note1;
            r_snap2      <= note2;
            r_position   <= '0;
            r_judged     <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_playing    <= 1'b1;
            r_done       <= 1'b0;
          end else if ((r_state == ST_DONE) && !w_mode_ok) begin
            r_state    <= ST_IDLE;
            r_position <= '0;
            r_judged   <= 1'b0;
            r_done     <= 1'b0;
          end
        end
        ST_PLAY: begin
          if (!w_mode_ok) begin
            r_state    <= ST_IDLE;
            r_position <= '0;
            r_judged   <= 1'b0;
            r_playing  <= 1'b0;
          end else begin
            if (w_press_hit) begin
              r_hit_count <= r_hit_count + 6'd1;
              r_hit_pulse <= 1'b1;
            end
            if (w_press_miss || w_eob_miss) begin
              r_miss_count <= r_miss_count + 6'd1;
              r_miss_pulse <= 1'b1;
            end
            if (w_judge) begin
              r_judged <= 1'b1;
            end
            if (w_tick) begin
              r_beat   <= 1'b1;
              r_judged <= 1'b0;
              if (r_position == LAST_POS) begin
                r_state   <= ST_DONE;
                r_playing <= 1'b0;
                r_done    <= 1'b1;
              end else begin
                r_position <= w_pos_inc;
              end
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_playing <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign position   = r_position;
  assign beat       = r_beat;
  assign playing    = r_playing;
  assign done       = r_done;
  assign hit_pulse  = r_hit_pulse;
  assign miss_pulse = r_miss_pulse;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

endmodule
